// File: rtl/dlsc_apb_arbiter.sv
// dlsc_apb_arbiter: round-robin arbiter that shares one APB master port between
// N valid/ready command requesters and returns a one-cycle response pulse.
// Optional ACCESS-phase watchdog enabled by defining DLSC_APB_ARB_TIMEOUT_EN.
module dlsc_apb_arbiter #(
  parameter int unsigned N       = 2,
  parameter int unsigned ADDR    = 32,
  parameter int unsigned DATA    = 32,
  parameter int unsigned STRB    = DATA/8,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [N*ADDR-1:0] in_addr,
  input  logic [N-1:0]      in_write,
  input  logic [N*DATA-1:0] in_wdata,
  input  logic [N*STRB-1:0] in_strb,
  output logic [N-1:0]      out_valid,
  output logic [DATA-1:0]   out_rdata,
  output logic              out_slverr,
  output logic [ADDR-1:0]   apb_addr,
  output logic              apb_sel,
  output logic              apb_enable,
  output logic              apb_write,
  output logic [DATA-1:0]   apb_wdata,
  output logic [STRB-1:0]   apb_strb,
  input  logic              apb_ready,
  input  logic [DATA-1:0]   apb_rdata,
  input  logic              apb_slverr
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Reject parameter values the arbiter and watchdog counter cannot represent
  if (N < 1 || N > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("dlsc_apb_arbiter: N or TIMEOUT out of range");
  end

  logic [1:0]      state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   gnt, gnt_n;
  logic [PW-1:0]   gsel;
  logic [PW-1:0]   idx;
  logic            found;
  logic            sel_n, en_n, write_n;
  logic [ADDR-1:0] addr_n;
  logic [DATA-1:0] wdata_n;
  logic [STRB-1:0] strb_n;
  logic [N-1:0]    ov_n;
  logic [DATA-1:0] rdata_n;
  logic            err_n;
`ifdef DLSC_APB_ARB_TIMEOUT_EN
  logic [CW-1:0]   cnt, cnt_n;
`endif

  // Round-robin pick: first valid requester at or above the pointer, wrapping
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gsel  = idx;
      end
    end
  end

  // Command accept handshake, only offered while idle
  assign in_ready = (state == ST_IDLE && found) ? (N'(1) << gsel) : '0;

  // Next-state and next-output logic for the transfer sequencer
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = apb_sel;
    en_n    = apb_enable;
    write_n = apb_write;
    addr_n  = apb_addr;
    wdata_n = apb_wdata;
    strb_n  = apb_strb;
    ov_n    = '0;
    rdata_n = out_rdata;
    err_n   = out_slverr;
`ifdef DLSC_APB_ARB_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_n = ST_SETUP;
          gnt_n   = gsel;
          sel_n   = 1'b1;
          write_n = in_write[gsel];
          addr_n  = in_addr[32'(gsel)*ADDR +: ADDR];
          wdata_n = in_wdata[32'(gsel)*DATA +: DATA];
          strb_n  = in_write[gsel] ? in_strb[32'(gsel)*STRB +: STRB] : '0;
          ptr_n   = (32'(gsel) == N - 1) ? '0 : gsel + PW'(1);
        end
      end
      ST_SETUP: begin
        state_n = ST_ACCESS;
        en_n    = 1'b1;
`ifdef DLSC_APB_ARB_TIMEOUT_EN
        cnt_n   = '0;
`endif
      end
      ST_ACCESS: begin
        if (apb_ready) begin
          state_n = ST_IDLE;
          sel_n   = 1'b0;
          en_n    = 1'b0;
          ov_n    = N'(1) << gnt;
          err_n   = apb_slverr;
          rdata_n = apb_write ? '0 : apb_rdata;
        end
`ifdef DLSC_APB_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = ST_IDLE;
          sel_n   = 1'b0;
          en_n    = 1'b0;
          ov_n    = N'(1) << gnt;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          cnt_n   = cnt + CW'(1);
        end
`endif
      end
      default: begin
        state_n = ST_IDLE;
        sel_n   = 1'b0;
        en_n    = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      gnt        <= '0;
      apb_sel    <= 1'b0;
      apb_enable <= 1'b0;
      apb_write  <= 1'b0;
      apb_addr   <= '0;
      apb_wdata  <= '0;
      apb_strb   <= '0;
      out_valid  <= '0;
      out_rdata  <= '0;
      out_slverr <= 1'b0;
`ifdef DLSC_APB_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      gnt        <= gnt_n;
      apb_sel    <= sel_n;
      apb_enable <= en_n;
      apb_write  <= write_n;
      apb_addr   <= addr_n;
      apb_wdata  <= wdata_n;
      apb_strb   <= strb_n;
      out_valid  <= ov_n;
      out_rdata  <= rdata_n;
      out_slverr <= err_n;
`ifdef DLSC_APB_ARB_TIMEOUT_EN
      cnt        <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_dlsc_apb_arbiter.sv
// Testbench for dlsc_apb_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level reference model.
module tb_dlsc_apb_arbiter;

  localparam int unsigned N       = 3;
  localparam int unsigned ADDR    = 32;
  localparam int unsigned DATA    = 32;
  localparam int unsigned STRB    = 4;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [N*ADDR-1:0] in_addr;
  logic [N-1:0]      in_write;
  logic [N*DATA-1:0] in_wdata;
  logic [N*STRB-1:0] in_strb;
  logic [N-1:0]      out_valid;
  logic [DATA-1:0]   out_rdata;
  logic              out_slverr;
  logic [ADDR-1:0]   apb_addr;
  logic              apb_sel;
  logic              apb_enable;
  logic              apb_write;
  logic [DATA-1:0]   apb_wdata;
  logic [STRB-1:0]   apb_strb;
  logic              apb_ready;
  logic [DATA-1:0]   apb_rdata;
  logic              apb_slverr;

  logic [ADDR-1:0] r_addr  [N];
  logic            r_write [N];
  logic [DATA-1:0] r_wdata [N];
  logic [STRB-1:0] r_strb  [N];

  dlsc_apb_arbiter #(.N(N), .ADDR(ADDR), .DATA(DATA), .STRB(STRB), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_write(in_write),
    .in_wdata(in_wdata), .in_strb(in_strb),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_slverr(out_slverr),
    .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_write(apb_write),
    .apb_wdata(apb_wdata), .apb_strb(apb_strb),
    .apb_ready(apb_ready), .apb_rdata(apb_rdata), .apb_slverr(apb_slverr)
  );

  always #5 clk = ~clk;

  // Flatten per-requester commands onto the bus ports
  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_addr[i*ADDR +: ADDR]  = r_addr[i];
      in_write[i]              = r_write[i];
      in_wdata[i*DATA +: DATA] = r_wdata[i];
      in_strb[i*STRB +: STRB]  = r_strb[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one outstanding transaction, timed from its accept cycle
  int              cyc = 0;
  bit              busy = 0;
  int              t_acc = 0;
  int              g = 0;
  int              ptr = 0;
  int              waits = 0;
  logic            cur_write = 1'b0;
  logic [ADDR-1:0] e_addr = '0;
  logic            e_write = 1'b0;
  logic [DATA-1:0] e_wdata = '0;
  logic [STRB-1:0] e_strb = '0;
  logic [N-1:0]    e_ov = '0;
  logic [DATA-1:0] e_rdata = '0;
  logic            e_err = 1'b0;
  logic [N-1:0]    acc_mask = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_grant();
    for (int k = 0; k < N; k++) begin
      if (in_valid[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic finish_txn(input logic [DATA-1:0] rd, input logic err);
    busy    = 0;
    e_ov    = N'(1) << g;
    e_rdata = cur_write ? '0 : rd;
    e_err   = err;
  endtask

  // One clock: check handshake, advance model, then check registered outputs
  task automatic tick();
    int gg;
    logic [N-1:0] exp_rdy;
    gg = -1;
    #1;
    acc_mask = '0;
    if (!rst) begin
      if (!busy) gg = rr_grant();
      exp_rdy = (gg >= 0) ? (N'(1) << gg) : '0;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
    end
    e_ov = '0;
    if (rst) begin
      busy = 0; ptr = 0;
      e_addr = '0; e_write = 1'b0; e_wdata = '0; e_strb = '0;
      e_rdata = '0; e_err = 1'b0;
    end else if (!busy) begin
      if (gg >= 0) begin
        busy = 1; t_acc = cyc; g = gg; waits = 0;
        acc_mask[gg] = 1'b1;
        cur_write = r_write[gg];
        e_addr  = r_addr[gg];
        e_write = r_write[gg];
        e_wdata = r_wdata[gg];
        e_strb  = r_write[gg] ? r_strb[gg] : '0;
        ptr = (gg + 1) % N;
      end
    end else if (cyc - t_acc >= 2) begin
      if (apb_ready) finish_txn(apb_rdata, apb_slverr);
`ifdef DLSC_APB_ARB_TIMEOUT_EN
      else begin
        waits++;
        if (waits == TIMEOUT) finish_txn('0, 1'b1);
      end
`endif
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("apb_sel", 64'(apb_sel), 64'(busy));
    check("apb_enable", 64'(apb_enable), 64'(busy && (cyc - t_acc >= 2)));
    check("apb_addr", 64'(apb_addr), 64'(e_addr));
    check("apb_write", 64'(apb_write), 64'(e_write));
    check("apb_wdata", 64'(apb_wdata), 64'(e_wdata));
    check("apb_strb", 64'(apb_strb), 64'(e_strb));
    check("out_valid", 64'(out_valid), 64'(e_ov));
    if (e_ov != '0) begin
      check("out_rdata", 64'(out_rdata), 64'(e_rdata));
      check("out_slverr", 64'(out_slverr), 64'(e_err));
    end
  endtask

  task automatic set_cmd(input int i, input logic [ADDR-1:0] a, input logic w,
                         input logic [DATA-1:0] d, input logic [STRB-1:0] s);
    r_addr[i] = a; r_write[i] = w; r_wdata[i] = d; r_strb[i] = s;
    in_valid[i] = 1'b1;
  endtask

  // Requesters withdraw a command once it has been taken
  task automatic drop_accepted();
    in_valid = in_valid & ~acc_mask;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem [2];
    int order;
    int done;
    int en_cnt;
    rst = 1'b1;
    in_valid = '0;
    apb_ready = 1'b0; apb_rdata = '0; apb_slverr = 1'b0;
    for (int i = 0; i < N; i++) set_cmd(i, '0, 1'b0, '0, '0);
    in_valid = '0;
    @(negedge clk);
    tick(); tick();
    check("rst_rdata", 64'(out_rdata), 64'(0));
    check("rst_slverr", 64'(out_slverr), 64'(0));
    rst = 1'b0;

    // Two requesters always valid: grants alternate starting at 0
    rem[0] = 4; rem[1] = 4; order = 0; done = 0;
    apb_ready = 1'b1;
    set_cmd(0, 32'h100, 1'b1, 32'h0, 4'hF);
    set_cmd(1, 32'h200, 1'b0, 32'h0, 4'hF);
    for (int t = 0; t < 60 && done < 8; t++) begin
      apb_rdata = $urandom;
      tick();
      if (e_ov != '0) done++;
      for (int i = 0; i < 2; i++) begin
        if (acc_mask[i]) begin
          check("rr_order", 64'(i), 64'(order % 2));
          order++;
          rem[i]--;
          if (rem[i] > 0) set_cmd(i, 32'h100 * (i + 1) + 32'(rem[i]), 1'(i == 0), $urandom, 4'hF);
          else in_valid[i] = 1'b0;
        end
      end
    end
    check("rr_done", 64'(done), 64'(8));

    // Zero-wait write from requester 0
    set_cmd(0, 32'h10, 1'b1, 32'hA5A5A5A5, 4'hF);
    apb_ready = 1'b1;
    tick(); drop_accepted();
    tick(); tick();
    check("t1_ov", 64'(out_valid), 64'(1));

    // Read with three wait states
    set_cmd(1, 32'h20, 1'b0, 32'h0, 4'hF);
    apb_ready = 1'b0;
    tick(); drop_accepted();
    en_cnt = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (apb_enable) en_cnt++;
    end
    apb_ready = 1'b1; apb_rdata = 32'h12345678;
    tick();
    check("t3_en_cycles", 64'(en_cnt), 64'(4));
    check("t3_rdata", 64'(out_rdata), 64'(32'h12345678));

    // Slave error on a write, then a clean transfer
    apb_slverr = 1'b1;
    set_cmd(2, 32'h30, 1'b1, 32'hDEADBEEF, 4'h3);
    tick(); drop_accepted(); tick(); tick();
    check("t4_err", 64'(out_slverr), 64'(1));
    apb_slverr = 1'b0;
    set_cmd(0, 32'h34, 1'b1, 32'h1, 4'h1);
    tick(); drop_accepted(); tick(); tick();
    check("t4_ok", 64'(out_slverr), 64'(0));

    // Reset while in ACCESS drops the transfer and the pointer
    set_cmd(1, 32'h40, 1'b0, 32'h0, 4'h0);
    apb_ready = 1'b0;
    tick(); drop_accepted(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_sel", 64'(apb_sel), 64'(0));
    set_cmd(0, 32'h44, 1'b0, 32'h0, 4'h0);
    set_cmd(1, 32'h48, 1'b0, 32'h0, 4'h0);
    #1;
    check("t5_ptr", 64'(in_ready), 64'(1));
    apb_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick(); drop_accepted();
    end

`ifdef DLSC_APB_ARB_TIMEOUT_EN
    // Slave never ready: watchdog aborts with an error
    apb_ready = 1'b0; apb_rdata = 32'hFFFF0000;
    set_cmd(0, 32'h50, 1'b0, 32'h0, 4'h0);
    tick(); drop_accepted();
    en_cnt = 0;
    for (int t = 0; t < TIMEOUT + 1; t++) begin
      tick();
      if (apb_enable) en_cnt++;
    end
    check("t6_en_cycles", 64'(en_cnt), 64'(TIMEOUT));
    check("t6_ov", 64'(out_valid), 64'(1));
    check("t6_err", 64'(out_slverr), 64'(1));
    check("t6_rdata", 64'(out_rdata), 64'(0));
`endif

    // Random traffic, random slave timing, occasional reset
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && ($urandom % 3 == 0))
          set_cmd(i, $urandom, 1'($urandom), $urandom, 4'($urandom));
      end
      apb_ready  = ($urandom % 3) != 0;
      apb_rdata  = $urandom;
      apb_slverr = ($urandom % 4) == 0;
      rst        = ($urandom % 400) == 0;
      tick();
      drop_accepted();
      if ($urandom % 8 == 0) in_valid[$urandom % N] = 1'b0;
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
